accum_ctrl_p: RTL and testbench
===============================

Name: accum_ctrl_p

Overview:
- Parametrised accumulator-machine control unit; the next generation of the 8-bit fetch/execute controller.
- Single-edge, FSM-sequenced design with a valid/ready memory handshake, so memories with variable latency are supported.
- Adds native multi-cycle MUL/DIV sequencing, a sticky halt/illegal status, and a configurable data width, address width and reset PC.
- Sits between the instruction/data memory, general ALU, multiplier, divider and the testbench/top level.

Parameters:
DATA_W, 8, accumulator/register/data-bus width; must be >= 8.
ADDR_W, 8, memory address width; must be <= DATA_W.
RESET_PC, 0, value loaded into R7 (PC) on reset.

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-high reset
mem_addr  out  ADDR_W  memory address
mem_req  out  1  memory request valid
mem_write  out  1  1 = store, 0 = read; qualified by mem_req
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  read data; instructions use bits [7:0]
mem_ready  in  1  request accepted/completed this cycle
alu_a, alu_b  out  DATA_W  ALU operands (acc, R[instr[2:0]])
alu_s  out  3  ALU select = instr[5:3]
alu_d  in  DATA_W  ALU result
alu_c  in  1  ALU carry out
mul_a, mul_b  out  DATA_W  multiplier operands (acc, R[instr[2:0]])
mul_p  in  DATA_W  product, combinational
div_a, div_b  out  DATA_W  divider operands (acc, R[instr[2:0]])
div_start  out  1  one-cycle divide start pulse
div_q  in  DATA_W  quotient
div_complete  in  1  quotient valid
pc  out  DATA_W  current R7
halted  out  1  sticky halt
illegal  out  1  sticky illegal-opcode flag

Behaviour:
- State: acc, R0..R7 (R7 = PC), instr[7:0], FSM. Reset: acc = 0, R0..R6 = 0, R7 = RESET_PC, instr = 0xFF, state FETCH, all outputs 0 except mem_addr = RESET_PC[ADDR_W-1:0].
- Reset mid-operation: mem_req, div_start and halted drop immediately (async); any in-flight access is abandoned.
- FETCH:
  - mem_req = 1, mem_write = 0, mem_addr = R7.
  - On a posedge with mem_ready: instr <= mem_rdata[7:0], R7 <= R7 + 1 (mod 2^DATA_W), go to EXEC.
  - Without mem_ready: hold all outputs stable.
- EXEC: one cycle, decoded on instr[7:4]; returns to FETCH unless noted.
  - 0000-0011 (ALU): acc <= alu_d.
  - 1000 MUL: acc <= mul_p.
  - 1100 SET: acc[3:0] <= instr[3:0]; upper bits unchanged.
  - 1101 MOV: if instr[3], R[instr[2:0]] <= acc, else acc <= R[instr[2:0]]. MOV to R7 is an absolute jump.
  - 1110 LD/ST: go to MEM.
  - 1001 DIV: div_start = 1 for this cycle only, then go to DIV_WAIT.
  - 0100 B: R7 <= R7 + sext(instr[3:0]). Offset is relative to the following instruction.
  - 0101 BZ: branch as B if acc == 0.
  - 0110 BNN: branch as B if acc[DATA_W-1] == 0.
  - 1111 NOP: no effect.
  - 1010 HLT: go to HALT.
  - Any other opcode: illegal <= 1, go to HALT.
- MEM:
  - mem_req = 1, mem_addr = R[instr[2:0]][ADDR_W-1:0], mem_write = instr[3], mem_wdata = acc.
  - On mem_ready: a load sets acc <= mem_rdata; then go to FETCH.
- DIV_WAIT:
  - Operands stay stable. On div_complete: acc <= div_q, go to FETCH.
  - div_complete sampled in the same cycle as div_start is ignored.
- HALT:
  - halted = 1, mem_req = 0; absorbing until reset.
- Latency with mem_ready tied high:
  - simple instruction = 2 cycles;
  - LD/ST = 3 cycles;
  - DIV = 3 + divider latency.
- PC wrap: 0xFF + 1 = 0x00 at DATA_W = 8. Branch arithmetic is modulo 2^DATA_W.
- Operand outputs are combinational from acc, instr and the register file.

Optional Feature:
CTRL_CARRY_EN
- Defined: a carry flag, reset 0, is loaded from alu_c on every ALU-class EXEC. Opcode 0111 = BC, which branches as B when carry = 1.
- Undefined: no flag; 0111 is illegal (sets illegal, halts).

Test Plan:
- Reset with RESET_PC = 0x10, mem_ready = 1: first mem_addr = 0x10, mem_req = 1; pc = 0x11 after the fetch.
- Program SET 5; MOV R1 (0xD9); SET 3; ADD R1 (0x01, alu_s = 0); HLT → acc = 0x08 (0x03 + 0x05), R1 = 0x05, halted = 1, mem_req = 0 thereafter.
- Stall handling: ST R2 with R2 = 0x40, acc = 0x5A, mem_ready held low 3 cycles → mem_req/mem_addr = 0x40/mem_wdata = 0x5A/mem_write = 1 stable for 4 cycles. A following LD R2 returns acc = 0x5A.
- Branching: acc = 0, BZ -2 (0x5E) at 0x20 → next fetch address 0x1F. acc = 0x80, BNN +3 → not taken, next fetch 0x21.
- DIV with acc = 20, R3 = 6, div_complete asserted 5 cycles after div_start → div_start high exactly 1 cycle, acc = 3, fetch resumes the cycle after.
- Illegal opcode 0x70 without CTRL_CARRY_EN → illegal = 1, halted = 1. Async reset mid-MEM clears both and mem_req the same cycle.

Source files
------------

// File: rtl/accum_ctrl_p.sv
// accum_ctrl_p: parametrised accumulator-machine control unit.
// Sequences FETCH -> EXEC -> (MEM | DIV_WAIT) -> FETCH over a valid/ready
// memory handshake. Drives the external ALU, multiplier and divider and keeps
// sticky halt/illegal status.
// Optional feature macro: CTRL_CARRY_EN adds a carry flag loaded by ALU-class
// instructions and the BC (opcode 0111) branch-on-carry instruction.
module accum_ctrl_p #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [DATA_W-1:0] RESET_PC = {DATA_W{1'b0}}
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_s,
    input  logic [DATA_W-1:0] alu_d,
    input  logic              alu_c,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic [DATA_W-1:0] mul_p,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    output logic              div_start,
    input  logic [DATA_W-1:0] div_q,
    input  logic              div_complete,
    output logic [DATA_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_EXEC     = 3'd1,
        S_MEM      = 3'd2,
        S_DIV_WAIT = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    localparam logic [3:0] OP_ALU0 = 4'h0;
    localparam logic [3:0] OP_ALU1 = 4'h1;
    localparam logic [3:0] OP_ALU2 = 4'h2;
    localparam logic [3:0] OP_ALU3 = 4'h3;
    localparam logic [3:0] OP_B    = 4'h4;
    localparam logic [3:0] OP_BZ   = 4'h5;
    localparam logic [3:0] OP_BNN  = 4'h6;
    localparam logic [3:0] OP_BC   = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_DIV  = 4'h9;
    localparam logic [3:0] OP_HLT  = 4'hA;
    localparam logic [3:0] OP_SET  = 4'hC;
    localparam logic [3:0] OP_MOV  = 4'hD;
    localparam logic [3:0] OP_LDST = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] regs_q [0:7];
    logic [DATA_W-1:0] regs_d [0:7];
    logic [7:0]        instr_q, instr_d;
    logic              illegal_q, illegal_d;

`ifdef CTRL_CARRY_EN
    logic              carry_q, carry_d;
`else
    logic              unused_s;
    assign unused_s = alu_c;
`endif

    logic [3:0]        opcode_s;
    logic [2:0]        rsel_s;
    logic [DATA_W-1:0] rval_s;
    logic [DATA_W-1:0] boff_s;

    assign opcode_s = instr_q[7:4];
    assign rsel_s   = instr_q[2:0];
    assign rval_s   = regs_q[rsel_s];
    // Branch offset is a signed nibble, applied to the already-incremented PC.
    assign boff_s   = {{(DATA_W-4){instr_q[3]}}, instr_q[3:0]};

    assign alu_a   = acc_q;
    assign alu_b   = rval_s;
    assign alu_s   = instr_q[5:3];
    assign mul_a   = acc_q;
    assign mul_b   = rval_s;
    assign div_a   = acc_q;
    assign div_b   = rval_s;
    assign pc      = regs_q[7];
    assign illegal = illegal_q;

    // Next-state logic: FSM sequencing, instruction execution and register-file update.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        regs_d    = regs_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;
`ifdef CTRL_CARRY_EN
        carry_d   = carry_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    instr_d   = mem_rdata[7:0];
                    regs_d[7] = regs_q[7] + ONE;
                    state_d   = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode_s)
                    OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3: begin
                        acc_d = alu_d;
`ifdef CTRL_CARRY_EN
                        carry_d = alu_c;
`endif
                    end
                    OP_MUL:  acc_d = mul_p;
                    OP_SET:  acc_d[3:0] = instr_q[3:0];
                    OP_MOV: begin
                        if (instr_q[3]) begin
                            regs_d[rsel_s] = acc_q;
                        end else begin
                            acc_d = rval_s;
                        end
                    end
                    OP_LDST: state_d = S_MEM;
                    OP_DIV:  state_d = S_DIV_WAIT;
                    OP_B:    regs_d[7] = regs_q[7] + boff_s;
                    OP_BZ: begin
                        if (acc_q == ZERO) begin
                            regs_d[7] = regs_q[7] + boff_s;
                        end else begin
                            regs_d[7] = regs_q[7];
                        end
                    end
                    OP_BNN: begin
                        if (!acc_q[DATA_W-1]) begin
                            regs_d[7] = regs_q[7] + boff_s;
                        end else begin
                            regs_d[7] = regs_q[7];
                        end
                    end
`ifdef CTRL_CARRY_EN
                    OP_BC: begin
                        if (carry_q) begin
                            regs_d[7] = regs_q[7] + boff_s;
                        end else begin
                            regs_d[7] = regs_q[7];
                        end
                    end
`endif
                    OP_NOP:  acc_d = acc_q;
                    OP_HLT:  state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (!instr_q[3]) begin
                        acc_d = mem_rdata;
                    end else begin
                        acc_d = acc_q;
                    end
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_DIV_WAIT: begin
                if (div_complete) begin
                    acc_d   = div_q;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DIV_WAIT;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Output decode from the state registers; reset masks the handshakes immediately.
    always_comb begin
        mem_req   = 1'b0;
        mem_write = 1'b0;
        mem_addr  = regs_q[7][ADDR_W-1:0];
        mem_wdata = ZERO;
        div_start = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: mem_req = ~reset;
            S_MEM: begin
                mem_req   = ~reset;
                mem_write = ~reset & instr_q[3];
                mem_addr  = rval_s[ADDR_W-1:0];
                mem_wdata = acc_q;
            end
            S_EXEC:     div_start = ~reset & (opcode_s == OP_DIV);
            S_DIV_WAIT: div_start = 1'b0;
            S_HALT:     halted    = ~reset;
            default:    halted    = 1'b0;
        endcase
    end

    // State register with asynchronous reset to the architectural reset values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            acc_q     <= ZERO;
            for (int i = 0; i < 7; i++) begin
                regs_q[i] <= ZERO;
            end
            regs_q[7] <= RESET_PC;
            instr_q   <= 8'hFF;
            illegal_q <= 1'b0;
`ifdef CTRL_CARRY_EN
            carry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            regs_q    <= regs_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
`ifdef CTRL_CARRY_EN
            carry_q   <= carry_d;
`endif
        end
    end

endmodule

// File: tb/tb_accum_ctrl_p.sv
// Testbench for accum_ctrl_p: directed scenarios plus random programs
// checked against an instruction-level reference interpreter.
module tb_accum_ctrl_p;

    logic       clock, reset;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_req, mem_write, mem_ready;
    logic [7:0] alu_a, alu_b, alu_d;
    logic [2:0] alu_s;
    logic       alu_c;
    logic [7:0] mul_a, mul_b, mul_p;
    logic [7:0] div_a, div_b, div_q;
    logic       div_start, div_complete;
    logic [7:0] pc;
    logic       halted, illegal;

    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] prog    [$];

    int checks = 0;
    int errors = 0;
    int div_lat = 2;

    // reference model state
    logic [7:0] m_acc;
    logic [7:0] m_r [0:7];
    logic       m_ill, m_cy;

    accum_ctrl_p #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h10)) dut (
        .clock(clock), .reset(reset),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_d(alu_d), .alu_c(alu_c),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .div_a(div_a), .div_b(div_b), .div_start(div_start), .div_q(div_q),
        .div_complete(div_complete),
        .pc(pc), .halted(halted), .illegal(illegal)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [8:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, a};
            3'd6:    return {1'b0, b};
            default: return {1'b0, ~a};
        endcase
    endfunction

    function automatic logic [7:0] mul8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = a * b;
        return p[7:0];
    endfunction

    function automatic logic [7:0] div8(input logic [7:0] a, input logic [7:0] b);
        return (b == 8'd0) ? 8'hFF : a / b;
    endfunction

    assign {alu_c, alu_d} = alu_f(alu_s, alu_a, alu_b);
    assign mul_p          = mul8(mul_a, mul_b);
    assign mem_rdata      = mem[mem_addr];

    // memory write port
    always @(posedge clock) begin
        if (mem_req && mem_ready && mem_write) mem[mem_addr] = mem_wdata;
    end

    // divider with programmable latency
    initial begin
        logic [7:0] a, b;
        div_complete = 1'b0;
        div_q = 8'h00;
        forever begin
            @(posedge clock);
            if (div_start) begin
                a = div_a;
                b = div_b;
                repeat (div_lat - 1) @(posedge clock);
                @(negedge clock);
                div_complete = 1'b1;
                div_q = div8(a, b);
                @(negedge clock);
                div_complete = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem(input logic [7:0] fill);
        for (int i = 0; i < 256; i++) mem[i] = fill;
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++) mem[8'h10 + i] = prog[i];
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic run_to_halt(input int budget, input bit rnd_ready, output int cyc);
        cyc = 0;
        while (!halted && cyc < budget) begin
            if (rnd_ready) mem_ready = ($urandom_range(0, 9) < 7);
            @(negedge clock);
            cyc++;
        end
        mem_ready = 1'b1;
        check_eq("halt_reached", halted, 1);
    endtask

    // Instruction-level interpreter over ref_mem.
    task automatic ref_run(output bit done);
        logic [7:0] ins, rv, off;
        logic [8:0] cr;
        m_acc = 8'h00;
        for (int i = 0; i < 7; i++) m_r[i] = 8'h00;
        m_r[7] = 8'h10;
        m_ill = 1'b0;
        m_cy = 1'b0;
        done = 1'b0;
        for (int step = 0; step < 120; step++) begin
            if (!done) begin
                ins = ref_mem[m_r[7]];
                m_r[7] = m_r[7] + 8'd1;
                rv = m_r[ins[2:0]];
                off = {{4{ins[3]}}, ins[3:0]};
                case (ins[7:4])
                    4'h0, 4'h1, 4'h2, 4'h3: begin
                        cr = alu_f(ins[5:3], m_acc, rv);
                        m_acc = cr[7:0];
                        m_cy = cr[8];
                    end
                    4'h4: m_r[7] = m_r[7] + off;
                    4'h5: if (m_acc == 8'h00) m_r[7] = m_r[7] + off;
                    4'h6: if (m_acc < 8'h80) m_r[7] = m_r[7] + off;
`ifdef CTRL_CARRY_EN
                    4'h7: if (m_cy) m_r[7] = m_r[7] + off;
`endif
                    4'h8: m_acc = mul8(m_acc, rv);
                    4'h9: m_acc = div8(m_acc, rv);
                    4'hA: done = 1'b1;
                    4'hC: m_acc = {m_acc[7:4], ins[3:0]};
                    4'hD: if (ins[3]) m_r[ins[2:0]] = m_acc; else m_acc = rv;
                    4'hE: if (ins[3]) ref_mem[rv] = m_acc; else m_acc = ref_mem[rv];
                    4'hF: ;
                    default: begin m_ill = 1'b1; done = 1'b1; end
                endcase
            end
        end
    endtask

    function automatic logic [7:0] gen_instr();
        logic [3:0] op, lo;
        int k;
        k = $urandom_range(0, 19);
        lo = 4'($urandom);
        case (k)
            0, 16:  op = 4'h0;
            1:      op = 4'h1;
            2:      op = 4'h2;
            3:      op = 4'h3;
            4:      op = 4'h4;
            5:      op = 4'h5;
            6:      op = 4'h6;
            7:      op = 4'h8;
            8, 17:  op = 4'h9;
            9, 10:  op = 4'hC;
            11, 12: op = 4'hD;
            13, 14: op = 4'hE;
            15:     op = 4'hF;
            18:     op = 4'hA;
            default: op = ($urandom_range(0, 1) == 1) ? 4'h7 : 4'hB;
        endcase
        if (op == 4'h4 || op == 4'h5 || op == 4'h6) lo[3] = 1'b0;
        if (op == 4'hD && lo == 4'hF) lo = 4'hE;
        return {op, lo};
    endfunction

    initial begin
        int cyc, n, starts, bad, tries;
        bit done;
        logic exp_ill;
        reset = 1'b0;
        mem_ready = 1'b1;

        // reset values
        clear_mem(8'hA0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_addr", mem_addr, 8'h10);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_illegal", illegal, 0);
        check_eq("rst_div_start", div_start, 0);
        check_eq("rst_mem_write", mem_write, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("first_req", mem_req, 1);
        check_eq("first_addr", mem_addr, 8'h10);
        @(negedge clock);
        check_eq("pc_after_fetch", pc, 8'h11);

        // SET 5; MOV R1; SET 3; ADD R1; HLT
        clear_mem(8'hA0);
        prog = '{8'hC5, 8'hD9, 8'hC3, 8'h01, 8'hA1};
        load_prog();
        do_reset();
        run_to_halt(50, 1'b0, cyc);
        check_eq("simple_latency", cyc, 10);
        check_eq("add_acc", alu_a, 8'h08);
        check_eq("add_r1", alu_b, 8'h05);
        check_eq("halt_req", mem_req, 0);
        @(negedge clock);
        check_eq("halt_sticky", halted, 1);

        // stalled store then load
        clear_mem(8'hA0);
        mem[0] = 8'h40;
        mem[1] = 8'h5A;
        prog = '{8'hC1, 8'hD9, 8'hE0, 8'hDA, 8'hE1, 8'hEA, 8'hC0, 8'hE2, 8'hA0};
        load_prog();
        do_reset();
        n = 0;
        while (!(mem_req && mem_write) && n < 100) begin @(negedge clock); n++; end
        check_eq("st_seen", mem_write, 1);
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check_eq("st_req", mem_req, 1);
            check_eq("st_addr", mem_addr, 8'h40);
            check_eq("st_wdata", mem_wdata, 8'h5A);
            check_eq("st_write", mem_write, 1);
            @(negedge clock);
        end
        run_to_halt(100, 1'b0, cyc);
        check_eq("ld_acc", alu_a, 8'h5A);
        check_eq("st_mem", mem[8'h40], 8'h5A);

        // BZ -2 taken at 0x20
        clear_mem(8'hF0);
        mem[8'h20] = 8'h5E;
        do_reset();
        n = 0;
        while (!(mem_req && mem_addr == 8'h20) && n < 100) begin @(negedge clock); n++; end
        check_eq("bz_seen", mem_addr, 8'h20);
        @(negedge clock);
        @(negedge clock);
        check_eq("bz_target", mem_addr, 8'h1F);
        check_eq("bz_req", mem_req, 1);

        // BNN +3 not taken with acc = 0x80
        clear_mem(8'hF0);
        mem[0] = 8'h80;
        mem[8'h10] = 8'hE0;
        mem[8'h20] = 8'h63;
        do_reset();
        n = 0;
        while (!(mem_req && mem_addr == 8'h20) && n < 100) begin @(negedge clock); n++; end
        check_eq("bnn_seen", mem_addr, 8'h20);
        @(negedge clock);
        @(negedge clock);
        check_eq("bnn_next", mem_addr, 8'h21);

        // DIV 20 / 6 with 5-cycle divider
        clear_mem(8'hA0);
        mem[0] = 8'h14;
        mem[1] = 8'h06;
        prog = '{8'hC1, 8'hD9, 8'hE1, 8'hDB, 8'hE0, 8'h93, 8'hA0};
        load_prog();
        div_lat = 5;
        do_reset();
        n = 0;
        while (!div_start && n < 100) begin @(negedge clock); n++; end
        check_eq("div_start_seen", div_start, 1);
        check_eq("div_a", div_a, 8'h14);
        check_eq("div_b", div_b, 8'h06);
        n = 0;
        starts = 1;
        do begin
            @(negedge clock);
            n++;
            starts += int'(div_start);
        end while (!mem_req && n < 30);
        check_eq("div_start_pulses", starts, 1);
        check_eq("div_resume_cycles", n, 6);
        check_eq("div_acc", alu_a, 8'h03);
        check_eq("div_next_addr", mem_addr, 8'h16);

        // illegal opcode 0x70 and async reset while halted
        clear_mem(8'hA0);
        mem[8'h10] = 8'h70;
        do_reset();
        run_to_halt(20, 1'b0, cyc);
`ifdef CTRL_CARRY_EN
        exp_ill = 1'b0;
`else
        exp_ill = 1'b1;
`endif
        check_eq("illegal_flag", illegal, exp_ill);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_halted", halted, 0);
        check_eq("arst_illegal", illegal, 0);

        // async reset in the middle of a stalled store
        clear_mem(8'hA0);
        mem[0] = 8'h33;
        mem[8'h10] = 8'hE8;
        do_reset();
        n = 0;
        while (!mem_write && n < 100) begin @(negedge clock); n++; end
        check_eq("mem_st_seen", mem_write, 1);
        mem_ready = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_mem_req", mem_req, 0);
        check_eq("arst_mem_write", mem_write, 0);
        @(negedge clock);
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_eq("arst_refetch", mem_addr, 8'h10);
        check_eq("arst_req_back", mem_req, 1);
        check_eq("arst_no_store", mem[0], 8'h33);

        // random programs against the reference interpreter
        for (int p = 0; p < 30; p++) begin
            done = 1'b0;
            tries = 0;
            while (!done && tries < 20) begin
                for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
                for (int a = 8'h10; a < 8'h40; a++) mem[a] = gen_instr();
                for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
                ref_run(done);
                tries++;
            end
            if (done) begin
                div_lat = $urandom_range(1, 4);
                do_reset();
                run_to_halt(4000, 1'b1, cyc);
                check_eq("rnd_pc", pc, m_r[7]);
                check_eq("rnd_acc", alu_a, m_acc);
                check_eq("rnd_illegal", illegal, m_ill);
                check_eq("rnd_req", mem_req, 0);
                bad = 0;
                for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
                check_eq("rnd_mem", bad, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
